imem_loader: RTL

Boot-time writer for the processor's 1024×32 instruction memory. It takes a byte stream over a valid/ready handshake, packs each group of four bytes into a little-endian 32-bit word, and writes the words to consecutive instruction-memory addresses starting at 0. The core only ever reads this memory; this block is the write side. While a load is in progress the block holds the core in reset, and it releases the core once the requested number of words has been written.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the boot loader.
// master = byte source / memory side, slave = the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_wren;
  logic [ADDR_W-1:0] im_address;
  logic [31:0]       im_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_wren, im_address, im_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_wren, im_address, im_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: packs a byte stream into little-endian
// words, writes them from address 0 upward and holds the core in reset meanwhile.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [ADDR_W:0] word_count_i,
  imem_loader_if.slave    bus,
  output logic            core_hold_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [7:0]      checksum_o
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  state_e            state_q,      state_d;
  logic [ADDR_W:0]   target_q,     target_d;
  logic [ADDR_W-1:0] word_addr_q,  word_addr_d;
  logic [1:0]        byte_idx_q,   byte_idx_d;
  logic [31:0]       word_q,       word_d;
  logic [7:0]        checksum_q,   checksum_d;
  logic [ADDR_W-1:0] im_address_q, im_address_d;
  logic [31:0]       im_data_q,    im_data_d;

  logic [ADDR_W:0]   target_clamped;
  logic [ADDR_W:0]   addr_next;

  assign target_clamped = (word_count_i > DEPTH_W) ? DEPTH_W : word_count_i;
  assign addr_next      = {1'b0, word_addr_q} + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d      = state_q;
    target_d     = target_q;
    word_addr_d  = word_addr_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    checksum_d   = checksum_q;
    im_address_d = im_address_q;
    im_data_d    = im_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          target_d    = target_clamped;
          word_addr_d = '0;
          byte_idx_d  = '0;
          checksum_d  = '0;
          state_d     = (target_clamped == '0) ? S_DONE : S_RECV;
        end
      end

      S_RECV: begin
        // byte_ready is exactly "in RECV", so valid alone marks an accepted byte
        if (bus.byte_valid) begin
          word_d[8*byte_idx_q +: 8] = bus.byte_data;
          checksum_d                = checksum_q ^ bus.byte_data;
          byte_idx_d                = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            im_address_d = word_addr_q;
            im_data_d    = {bus.byte_data, word_q[23:0]};
            state_d      = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (addr_next == target_q) begin
          state_d = S_DONE;
        end else begin
          word_addr_d = addr_next[ADDR_W-1:0];
          byte_idx_d  = '0;
          state_d     = S_RECV;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      word_addr_q  <= '0;
      byte_idx_q   <= '0;
      // NOTE: the assembly register is reset too, so im_data never carries X after boot.
      word_q       <= '0;
      checksum_q   <= '0;
      im_address_q <= '0;
      im_data_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q      <= state_d;
      target_q     <= target_d;
      word_addr_q  <= word_addr_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      checksum_q   <= checksum_d;
      im_address_q <= im_address_d;
      im_data_q    <= im_data_d;
    end
  end

  assign bus.byte_ready = (state_q == S_RECV);
  assign bus.im_wren    = (state_q == S_WRITE);
  assign bus.im_address = im_address_q;
  assign bus.im_data    = im_data_q;

  assign core_hold_o = (state_q != S_DONE);
  assign busy_o      = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done_o      = (state_q == S_DONE);
  assign checksum_o  = checksum_q;

endmodule
